// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

    localparam int unsigned UART_D_W   = 8;
    localparam int unsigned UART_DEPTH = 64;

    // Drain sequencer states
    typedef enum logic [2:0] {
        D_IDLE,
        D_READ,
        D_LOAD,
        D_ACK,
        D_WAIT
    } drain_state_t;

    // Index of a byte requester (0 or 1)
    typedef logic [0:0] req_idx_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester, transmitter and status signals of the UART transmit scheduler.
interface uart_tx_sched_if
    import uart_pkg::*;
#(
    parameter int unsigned D_W = UART_D_W
);

    logic           req0_valid;
    logic [D_W-1:0] req0_data;
    logic           req0_ready;
    logic           req1_valid;
    logic [D_W-1:0] req1_data;
    logic           req1_ready;
    logic           tx_start;
    logic [D_W-1:0] tx_data;
    logic           tx_busy;
    logic           fifo_full;
    logic           fifo_empty;

    // Side that supplies bytes and owns the transmitter
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        input  req0_ready, req1_ready, tx_start, tx_data, fifo_full, fifo_empty
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        output req0_ready, req1_ready, tx_start, tx_data, fifo_full, fifo_empty
    );

endinterface

// File: rtl/uart_tx_sched_fifo.sv
// Synchronous FIFO with registered read data; a write takes priority over a
// read issued in the same cycle, so callers must never assert both.
module fifo
    import uart_pkg::*;
#(
    parameter int unsigned D_W   = UART_D_W,
    parameter int unsigned DEPTH = UART_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [D_W-1:0] data_in,
    input  logic           rd_en,
    output logic [D_W-1:0] data_out,
    output logic           full,
    output logic           empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [D_W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_wr;
    logic           do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !wr_en && !empty;

    // Storage array, written without reset
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy count and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + (AW+1)'(1);
        end else if (do_rd) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + AW'(1);
            count    <= count - (AW+1)'(1);
        end
    end

    no_simultaneous_access: assert property (@(posedge clk) disable iff (rst) !(wr_en && rd_en));

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: round-robin merge of two byte sources into one FIFO,
// drained one byte at a time into the UART transmitter.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned D_W   = UART_D_W,
    parameter int unsigned DEPTH = UART_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_sched_if.slave  bus
);

    drain_state_t   state;
    req_idx_t       last;
    logic           grant_ok;
    logic           grant0;
    logic           grant1;
    logic           wr_en;
    logic           rd_en;
    logic [D_W-1:0] wr_data;
    logic [D_W-1:0] rd_data;
    logic           full;
    logic           empty;
    logic           tx_start_q;
    logic [D_W-1:0] tx_data_q;

    // Round-robin write grant; held off during reset, when full, and in the read cycle
    always_comb begin
        grant_ok = !rst && !full && (state != D_READ);
        grant0   = grant_ok && bus.req0_valid && (!bus.req1_valid || last == 1'b1);
        grant1   = grant_ok && bus.req1_valid && (!bus.req0_valid || last == 1'b0);
        wr_en    = grant0 || grant1;
        wr_data  = grant1 ? bus.req1_data : bus.req0_data;
    end

    assign rd_en          = (state == D_READ);
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;

    // Remember which requester was served most recently; resets so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (grant0) begin
            last <= 1'b0;
        end else if (grant1) begin
            last <= 1'b1;
        end
    end

    // Drain sequencer: read one byte, present it with a one-cycle start pulse, follow busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= D_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state)
                D_IDLE: begin
                    if (!empty && !bus.tx_busy) begin
                        state <= D_READ;
                    end
                end
                D_READ: begin
                    state <= D_LOAD;
                end
                D_LOAD: begin
                    tx_data_q  <= rd_data;
                    tx_start_q <= 1'b1;
                    state      <= D_ACK;
                end
                D_ACK: begin
                    if (bus.tx_busy) begin
                        state <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    if (!bus.tx_busy) begin
                        state <= D_IDLE;
                    end
                end
                default: begin
                    state <= D_IDLE;
                end
            endcase
        end
    end

    fifo #(
        .D_W   (D_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .data_in  (wr_data),
        .rd_en    (rd_en),
        .data_out (rd_data),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized and directed bench for uart_tx_sched against a queue-based model.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int unsigned DW  = UART_D_W;
    localparam int unsigned DEP = UART_DEPTH;

    logic clk;
    logic rst;

    uart_tx_sched_if #(.D_W(DW)) bus ();

    uart_tx_sched #(.D_W(DW), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned   checks     = 0;
    int unsigned   errors     = 0;
    int unsigned   cyc        = 0;
    int unsigned   n_starts   = 0;
    int unsigned   busy_len   = 2;
    int unsigned   busy_left  = 0;
    bit            busy_force = 1'b0;
    bit            start_seen = 1'b0;
    bit            rand_busy  = 1'b0;
    bit            exp_last   = 1'b1;
    logic [DW-1:0] acc_q[$];
    int unsigned   start_cyc[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v0, input logic [DW-1:0] d0, input logic v1, input logic [DW-1:0] d1);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        set_req(1'b0, '0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait until every accepted byte has been transmitted and the transmitter is quiet
    task automatic drain_wait(input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (acc_q.size() == 0 && bus.fifo_empty && !bus.tx_busy) break;
        end
        check_val("drain_left", 32'(acc_q.size()), 0);
    endtask

    function automatic logic [DW-1:0] rr_exp(input int unsigned k);
        logic [DW-1:0] base;
        base = (k % 2 == 0) ? 8'h10 : 8'h20;
        return base + DW'(k / 2);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Transmitter model: busy from the cycle after a start pulse, for busy_len cycles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (start_seen) begin
                busy_left  = busy_len;
                start_seen = 1'b0;
            end
            bus.tx_busy = busy_force || (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
    end

    // Scoreboard: accepted bytes in order, round-robin rule, transmitted bytes in order
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_q.delete();
                exp_last = 1'b1;
            end else begin
                if (bus.tx_start) begin
                    n_starts++;
                    start_cyc.push_back(cyc);
                    start_seen = 1'b1;
                    if (rand_busy) busy_len = $urandom_range(1, 4);
                    check_val("tx_has_byte", 32'(acc_q.size() > 0), 1);
                    if (acc_q.size() > 0) check_val("tx_data", 32'(bus.tx_data), 32'(acc_q.pop_front()));
                end
                if (bus.fifo_full) begin
                    check_val("full_no_grant", 32'(bus.req0_ready || bus.req1_ready), 0);
                end
                if (bus.req0_ready || bus.req1_ready) begin
                    check_val("one_grant", 32'(bus.req0_ready && bus.req1_ready), 0);
                    check_val("grant_needs_valid",
                              32'((bus.req0_ready && !bus.req0_valid) || (bus.req1_ready && !bus.req1_valid)), 0);
                    if (bus.req0_valid && bus.req1_valid) begin
                        check_val("rr_pick", 32'(bus.req1_ready), 32'(!exp_last));
                    end
                    if (bus.req0_ready && bus.req0_valid) begin
                        acc_q.push_back(bus.req0_data);
                        exp_last = 1'b0;
                    end else if (bus.req1_ready && bus.req1_valid) begin
                        acc_q.push_back(bus.req1_data);
                        exp_last = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned k;
        int unsigned n;
        int unsigned r;
        int unsigned got;
        int unsigned base;
        int unsigned n0;
        bit          found;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;

        rst         = 1'b1;
        bus.tx_busy = 1'b0;
        set_req(1'b1, 8'h55, 1'b1, 8'h66);

        // Reset values, with both requesters valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_tx_start", 32'(bus.tx_start), 0);
        check_val("rst_tx_data", 32'(bus.tx_data), 0);
        check_val("rst_ready0", 32'(bus.req0_ready), 0);
        check_val("rst_ready1", 32'(bus.req1_ready), 0);
        check_val("rst_empty", 32'(bus.fifo_empty), 1);
        check_val("rst_full", 32'(bus.fifo_full), 0);
        tick();
        rst = 1'b0;
        set_req(1'b0, '0, 1'b0, '0);
        tick();

        // Single byte: accepted in t, start pulse in t+4
        set_req(1'b1, 8'hA5, 1'b0, '0);
        @(negedge clk);
        check_val("single_ready", 32'(bus.req0_ready), 1);
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        for (int unsigned j = 1; j <= 5; j++) begin
            @(negedge clk);
            check_val("single_start", 32'(bus.tx_start), 32'(j == 4));
            if (j == 1) check_val("single_nonempty", 32'(bus.fifo_empty), 0);
            if (j == 3) check_val("single_empty_after_read", 32'(bus.fifo_empty), 1);
            if (j == 4) check_val("single_data", 32'(bus.tx_data), 32'h a5);
        end
        drain_wait(100);

        // Round-robin with both requesters held valid
        do_reset();
        d0 = 8'h10;
        d1 = 8'h20;
        k  = 0;
        set_req(1'b1, d0, 1'b1, d1);
        for (int unsigned i = 0; i < 300 && k < 8; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin
                check_val("rr_order", 32'(bus.req0_data), 32'(rr_exp(k)));
                k++;
                d0++;
            end else if (bus.req1_ready) begin
                check_val("rr_order", 32'(bus.req1_data), 32'(rr_exp(k)));
                k++;
                d1++;
            end
            tick();
            set_req(k < 8, d0, k < 8, d1);
        end
        check_val("rr_count", k, 8);
        set_req(1'b0, '0, 1'b0, '0);
        drain_wait(400);

        // Fill the FIFO while the transmitter is held busy, then release
        busy_force = 1'b1;
        busy_len   = 3;
        do_reset();
        n = 0;
        for (int unsigned i = 0; i < 300 && n < DEP; i++) begin
            set_req(1'b1, DW'(n), 1'b0, '0);
            @(negedge clk);
            if (bus.req0_ready) n++;
            tick();
        end
        check_val("full_accepted", n, DEP);
        set_req(1'b1, 8'hF0, 1'b1, 8'hF1);
        for (int unsigned j = 0; j < 2; j++) begin
            @(negedge clk);
            check_val("full_flag", 32'(bus.fifo_full), 1);
            check_val("full_ready0", 32'(bus.req0_ready), 0);
            check_val("full_ready1", 32'(bus.req1_ready), 0);
        end
        busy_force = 1'b0;
        r   = cyc + 1;
        got = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                got = cyc;
                check_val("full_flag_clear", 32'(bus.fifo_full), 0);
                break;
            end
        end
        check_val("full_resume_cycle", got, r + 2);
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        drain_wait(1500);

        // Transmitter handshake with a long busy period
        busy_force = 1'b1;
        busy_len   = 10;
        n = 0;
        for (int unsigned i = 0; i < 50 && n < 3; i++) begin
            tick();
            set_req(1'b0, '0, 1'b1, DW'(8'hC0 + n));
            @(negedge clk);
            if (bus.req1_ready) n++;
        end
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        base = start_cyc.size();
        @(negedge clk);
        busy_force = 1'b0;
        drain_wait(300);
        check_val("hs_starts", 32'(start_cyc.size() - base), 3);
        if (start_cyc.size() >= base + 3) begin
            for (int unsigned i = 0; i < 2; i++) begin
                check_val("hs_gap", 32'(start_cyc[base+i+1] - start_cyc[base+i] >= busy_len + 5), 1);
            end
        end

        // Random requesters and random busy lengths
        rand_busy = 1'b1;
        for (int unsigned i = 0; i < 500; i++) begin
            tick();
            set_req(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom));
        end
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        drain_wait(1500);
        rand_busy = 1'b0;

        // Reset while a byte is in its start cycle with three more queued
        busy_len   = 4;
        busy_force = 1'b1;
        n = 0;
        for (int unsigned i = 0; i < 50 && n < 4; i++) begin
            tick();
            set_req(1'b1, DW'(8'h90 + n), 1'b0, '0);
            @(negedge clk);
            if (bus.req0_ready) n++;
        end
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        busy_force = 1'b0;
        found = 1'b0;
        for (int unsigned i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.tx_start) begin
                found = 1'b1;
                break;
            end
        end
        check_val("rmid_start_seen", 32'(found), 1);
        tick();
        rst = 1'b1;
        set_req(1'b1, 8'h77, 1'b1, 8'h88);
        n0 = n_starts;
        check_val("rmid_queued", 32'(acc_q.size()), 3);
        @(negedge clk);
        check_val("rmid_ready0", 32'(bus.req0_ready), 0);
        check_val("rmid_ready1", 32'(bus.req1_ready), 0);
        check_val("rmid_tx_start", 32'(bus.tx_start), 0);
        tick();
        @(negedge clk);
        check_val("rmid_ready0_b", 32'(bus.req0_ready), 0);
        check_val("rmid_tx_start_b", 32'(bus.tx_start), 0);
        check_val("rmid_empty", 32'(bus.fifo_empty), 1);
        tick();
        rst = 1'b0;
        set_req(1'b0, '0, 1'b0, '0);
        for (int unsigned i = 0; i < 30; i++) begin
            @(negedge clk);
            check_val("rmid_quiet", 32'(bus.tx_start), 0);
        end
        check_val("rmid_no_start", n_starts - n0, 0);
        check_val("rmid_empty_after", 32'(bus.fifo_empty), 1);
        tick();
        set_req(1'b1, 8'h3C, 1'b0, '0);
        @(negedge clk);
        check_val("rmid_new_ready", 32'(bus.req0_ready), 1);
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        drain_wait(100);
        check_val("rmid_recover", n_starts - n0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
